// File: rtl/window_bit_serializer_if.sv
// Word handshake plus serial-output bundle for window_bit_serializer.
// The producer uses the master modport; the serializer uses the slave modport.
interface window_bit_serializer_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             out;
   logic             out_valid;
   logic             busy;
   logic [LVL_W-1:0] level;

   modport master (
      output din, din_valid,
      input  din_ready, out, out_valid, busy, level
   );

   modport slave (
      input  din, din_valid,
      output din_ready, out, out_valid, busy, level
   );
endinterface

// File: rtl/window_bit_serializer.sv
// Small-FIFO word buffer feeding an MSB-first bit shifter with optional idle gaps.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module window_bit_serializer #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned GAP   = 0
) (
   input logic                   clk,
   input logic                   rst,
   window_bit_serializer_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
`ifdef SERIALIZER_PARITY_EN
   localparam int unsigned NBITS = WIDTH + 1;
`else
   localparam int unsigned NBITS = WIDTH;
`endif
   localparam int unsigned CNT_W = $clog2(NBITS);
   localparam int unsigned GAP_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             out_q, out_d;
   logic             out_valid_q, out_valid_d;
`ifdef SERIALIZER_PARITY_EN
   logic             par_q, par_d;
`endif
   logic             push;
   logic             pop;
   logic             decide;
   logic [WIDTH-1:0] head;

   // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot.
   assign bus.din_ready = (level_q != LVL_W'(DEPTH)) && !rst;
   assign push          = bus.din_valid && bus.din_ready;
   assign head          = mem_q[rd_ptr_q];

   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.level     = level_q;
   assign bus.busy      = (state_q != ST_IDLE) || (level_q != '0);

   // FIFO storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         mem_d[wr_ptr_q] = bus.din;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // Shifter next-state: cnt_q counts the bits still to present after the current one.
   always_comb begin
      state_d     = state_q;
      sh_d        = sh_q;
      cnt_d       = cnt_q;
      gap_d       = gap_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
`ifdef SERIALIZER_PARITY_EN
      par_d       = par_q;
`endif
      decide      = 1'b0;
      pop         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            decide = 1'b1;
         end
         ST_SHIFT: begin
            if (cnt_q != '0) begin
               out_d = sh_q[WIDTH-1];
`ifdef SERIALIZER_PARITY_EN
               if (cnt_q == CNT_W'(1)) begin
                  out_d = par_q;
               end
`endif
               sh_d  = sh_q << 1;
               cnt_d = cnt_q - CNT_W'(1);
            end else if (GAP != 0) begin
               state_d     = ST_GAP;
               out_valid_d = 1'b0;
               gap_d       = GAP_W'(GAP - 1);
            end else begin
               decide = 1'b1;
            end
         end
         ST_GAP: begin
            if (gap_q != '0) begin
               gap_d = gap_q - GAP_W'(1);
            end else begin
               decide = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Shared word-boundary decision: start the next word or fall back to idle.
      if (decide) begin
         if (level_q != '0) begin
            pop         = 1'b1;
            state_d     = ST_SHIFT;
            sh_d        = head << 1;
            out_d       = head[WIDTH-1];
            out_valid_d = 1'b1;
            cnt_d       = CNT_W'(NBITS - 1);
`ifdef SERIALIZER_PARITY_EN
            par_d       = ^head;
`endif
         end else begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         sh_q        <= '0;
         cnt_q       <= '0;
         gap_q       <= '0;
         out_q       <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         sh_q        <= sh_d;
         cnt_q       <= cnt_d;
         gap_q       <= gap_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
`ifdef SERIALIZER_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end
endmodule

// File: tb/tb_window_bit_serializer.sv
// Bench for window_bit_serializer: a GAP=0 and a GAP=2 instance checked every cycle
// against a timeline model (each word's start edge derived from accept time and spacing).
module tb_window_bit_serializer;
   localparam int WIDTH = 4;
   localparam int DEPTH = 4;
   localparam int LVL_W = $clog2(DEPTH) + 1;
`ifdef SERIALIZER_PARITY_EN
   localparam int NB = WIDTH + 1;
`else
   localparam int NB = WIDTH;
`endif
   localparam int MAXW = 256;

   logic clk = 1'b0;
   logic rst;

   window_bit_serializer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus0 ();
   window_bit_serializer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus2 ();

   window_bit_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAP(0)) u_dut0 (
      .clk(clk), .rst(rst), .bus(bus0)
   );
   window_bit_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAP(2)) u_dut2 (
      .clk(clk), .rst(rst), .bus(bus2)
   );

   always #5 clk = ~clk;

   logic [WIDTH-1:0] m_word  [2][MAXW];
   int               m_start [2][MAXW];
   int               m_n     [2];
   int               m_free  [2];
   logic             m_last  [2];
   logic [WIDTH-1:0] pend0[$];
   logic [WIDTH-1:0] pend2[$];
   logic [1:0]       cap0[$];
   logic [1:0]       cap2[$];
   int               max_lvl0;
   int               cyc;
   int               errors;
   int               checks;
   bit               rnd_vld;

   function automatic int gap_of(input int d);
      return (d == 0) ? 0 : 2;
   endfunction

   function automatic logic bit_of(input logic [WIDTH-1:0] w, input int k);
      if (k < WIDTH) return w[WIDTH-1-k];
      return ^w;
   endfunction

   function automatic int m_level(input int d, input int t);
      int n = 0;
      for (int i = 0; i < m_n[d]; i++) if (m_start[d][i] > t) n++;
      return n;
   endfunction

   function automatic logic m_busy(input int d, input int t);
      logic b = (m_level(d, t) != 0);
      for (int i = 0; i < m_n[d]; i++)
         if (t >= m_start[d][i] && t < m_start[d][i] + NB + gap_of(d)) b = 1'b1;
      return b;
   endfunction

   task automatic m_expect(input int d, input int t, output logic ev, output logic eo,
                           output int el, output logic eb);
      ev = 1'b0;
      eo = m_last[d];
      el = m_level(d, t);
      eb = m_busy(d, t);
      for (int i = 0; i < m_n[d]; i++) begin
         if (t >= m_start[d][i] && t < m_start[d][i] + NB) begin
            ev = 1'b1;
            eo = bit_of(m_word[d][i], t - m_start[d][i]);
         end
      end
      if (ev) m_last[d] = eo;
   endtask

   // One clock: drive, check ready, advance model at the edge, check outputs after it.
   task automatic tick();
      logic             vld   [2];
      logic [WIDTH-1:0] dat   [2];
      logic             rdy_m [2];
      logic             o_rdy [2];
      logic             o_v   [2];
      logic             o_o   [2];
      logic             o_b   [2];
      logic [LVL_W-1:0] o_l   [2];
      logic             ev, eo, eb;
      int               el, s;
      vld[0] = (pend0.size() != 0) && (!rnd_vld || ($urandom_range(0, 3) != 0));
      vld[1] = (pend2.size() != 0) && (!rnd_vld || ($urandom_range(0, 3) != 0));
      dat[0] = (pend0.size() != 0) ? pend0[0] : WIDTH'($urandom);
      dat[1] = (pend2.size() != 0) ? pend2[0] : WIDTH'($urandom);
      bus0.din = dat[0]; bus0.din_valid = vld[0];
      bus2.din = dat[1]; bus2.din_valid = vld[1];
      #1;
      o_rdy[0] = bus0.din_ready;
      o_rdy[1] = bus2.din_ready;
      for (int d = 0; d < 2; d++) begin
         rdy_m[d] = !rst && (m_level(d, cyc) < DEPTH);
         checks++;
         if (o_rdy[d] !== rdy_m[d]) begin
            errors++;
            $display("FAIL din_ready dut%0d cyc %0d: got %b want %b", d, cyc, o_rdy[d], rdy_m[d]);
         end
      end
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_n[d] = 0; m_free[d] = 0; m_last[d] = 1'b0;
         end else if (vld[d] && rdy_m[d] && m_n[d] < MAXW) begin
            s = (cyc + 1 > m_free[d]) ? cyc + 1 : m_free[d];
            m_word[d][m_n[d]]  = dat[d];
            m_start[d][m_n[d]] = s;
            m_n[d]++;
            m_free[d] = s + NB + gap_of(d);
            if (d == 0) void'(pend0.pop_front());
            else        void'(pend2.pop_front());
         end
      end
      #1;
      o_v[0] = bus0.out_valid; o_o[0] = bus0.out; o_l[0] = bus0.level; o_b[0] = bus0.busy;
      o_v[1] = bus2.out_valid; o_o[1] = bus2.out; o_l[1] = bus2.level; o_b[1] = bus2.busy;
      for (int d = 0; d < 2; d++) begin
         m_expect(d, cyc, ev, eo, el, eb);
         checks++;
         if (o_v[d] !== ev) begin
            errors++;
            $display("FAIL out_valid dut%0d cyc %0d: got %b want %b", d, cyc, o_v[d], ev);
         end
         checks++;
         if (o_o[d] !== eo) begin
            errors++;
            $display("FAIL out dut%0d cyc %0d: got %b want %b", d, cyc, o_o[d], eo);
         end
         checks++;
         if (o_l[d] !== LVL_W'(el)) begin
            errors++;
            $display("FAIL level dut%0d cyc %0d: got %0d want %0d", d, cyc, o_l[d], el);
         end
         checks++;
         if (o_b[d] !== eb) begin
            errors++;
            $display("FAIL busy dut%0d cyc %0d: got %b want %b", d, cyc, o_b[d], eb);
         end
      end
      cap0.push_back({o_v[0], o_o[0]});
      cap2.push_back({o_v[1], o_o[1]});
      if (int'(o_l[0]) > max_lvl0) max_lvl0 = int'(o_l[0]);
      @(negedge clk);
   endtask

   task automatic run_until_idle(input string name, input int budget);
      int n = 0;
      while ((pend0.size() != 0 || pend2.size() != 0 || m_busy(0, cyc) || m_busy(1, cyc))
             && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s drain: still busy after %0d cycles, required idle", name, n);
      end
      repeat (2) tick();
   endtask

   // Valid bits of dut0's capture, MSB-first packed, plus count and contiguity.
   task automatic valid_bits0(output logic [127:0] bits, output int nv, output logic contig);
      int first = -1, last = -1;
      bits = '0; nv = 0;
      foreach (cap0[i]) begin
         if (cap0[i][1]) begin
            bits = {bits[126:0], cap0[i][0]};
            nv++;
            if (first < 0) first = i;
            last = i;
         end
      end
      contig = (nv == 0) || (last - first + 1 == nv);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus0.din_valid = 1'b0; bus2.din_valid = 1'b0;
      repeat (2) tick();
      checks++;
      if (bus0.out !== 1'b0 || bus0.out_valid !== 1'b0 || bus0.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got out=%b valid=%b busy=%b want 0 0 0",
                  bus0.out, bus0.out_valid, bus0.busy);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (bus0.din_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset: got %b want 1", bus0.din_ready);
      end
      tick();
   endtask

   task automatic test_single();
      logic [127:0] bits; int nv; logic contig;
      cap0.delete(); cap2.delete();
      pend0.push_back(4'b1011); pend2.push_back(4'b1011);
      run_until_idle("single", 40);
      valid_bits0(bits, nv, contig);
      checks++;
      if (nv != NB || !contig) begin
         errors++;
         $display("FAIL single_valid_count: got %0d contig=%b want %0d contig=1", nv, contig, NB);
      end
`ifndef SERIALIZER_PARITY_EN
      checks++;
      if (bits[3:0] !== 4'b1011) begin
         errors++;
         $display("FAIL single_bits: got %b want 1011", bits[3:0]);
      end
`endif
      checks++;
      if (bus0.out !== 1'b1 || bus0.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_hold: got out=%b valid=%b want 1 0", bus0.out, bus0.out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] bits, exp; int nv; logic contig;
      cap0.delete(); cap2.delete();
      max_lvl0 = 0;
      exp = '0;
      for (int w = 1; w <= 15; w++) begin
         pend0.push_back(WIDTH'(w));
         pend2.push_back(WIDTH'(w));
         exp = {exp[123:0], 4'(w)};
      end
      run_until_idle("back_to_back", 300);
      valid_bits0(bits, nv, contig);
      checks++;
      if (nv != 15 * NB || !contig) begin
         errors++;
         $display("FAIL b2b_stream_shape: got %0d bits contig=%b want %0d contig=1",
                  nv, contig, 15 * NB);
      end
`ifndef SERIALIZER_PARITY_EN
      checks++;
      if (bits[59:0] !== exp[59:0]) begin
         errors++;
         $display("FAIL b2b_stream: got %h want %h", bits[59:0], exp[59:0]);
      end
`endif
      checks++;
      if (max_lvl0 != DEPTH) begin
         errors++;
         $display("FAIL b2b_fill: got max level %0d want %0d", max_lvl0, DEPTH);
      end
   endtask

   task automatic test_gap();
      logic [1:0] exp [10];
      int first = -1;
      cap0.delete(); cap2.delete();
      pend0.push_back(4'b1100); pend0.push_back(4'b0011);
      pend2.push_back(4'b1100); pend2.push_back(4'b0011);
      run_until_idle("gap", 60);
`ifndef SERIALIZER_PARITY_EN
      exp = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11};
      foreach (cap2[i]) if (first < 0 && cap2[i][1]) first = i;
      checks++;
      if (first < 0 || first + 10 > cap2.size()) begin
         errors++;
         $display("FAIL gap_window: got start %0d size %0d want a 10-cycle window",
                  first, cap2.size());
      end else begin
         for (int k = 0; k < 10; k++) begin
            checks++;
            if (cap2[first + k] !== exp[k]) begin
               errors++;
               $display("FAIL gap_seq[%0d]: got valid/out %b want %b", k, cap2[first + k], exp[k]);
            end
         end
      end
`endif
   endtask

   task automatic test_reset_mid();
      logic [127:0] bits; int nv; logic contig;
      cap0.delete(); cap2.delete();
      pend0.push_back(4'b1010); pend0.push_back(4'b0110);
      pend2.push_back(4'b1010); pend2.push_back(4'b0110);
      repeat (3) tick();
      checks++;
      if (bus0.out_valid !== 1'b1 || bus0.out !== 1'b0) begin
         errors++;
         $display("FAIL mid_second_bit: got valid=%b out=%b want 1 0", bus0.out_valid, bus0.out);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (bus0.out !== 1'b0 || bus0.out_valid !== 1'b0 || bus0.level !== '0) begin
         errors++;
         $display("FAIL mid_abort: got out=%b valid=%b level=%0d want 0 0 0",
                  bus0.out, bus0.out_valid, bus0.level);
      end
      rst = 1'b0;
      cap0.delete(); cap2.delete();
      pend0.push_back(4'b1001); pend2.push_back(4'b1001);
      run_until_idle("reset_mid", 40);
      valid_bits0(bits, nv, contig);
      checks++;
      if (nv != NB || !contig) begin
         errors++;
         $display("FAIL mid_restart_count: got %0d want %0d", nv, NB);
      end
`ifndef SERIALIZER_PARITY_EN
      checks++;
      if (bits[3:0] !== 4'b1001) begin
         errors++;
         $display("FAIL mid_restart_bits: got %b want 1001", bits[3:0]);
      end
`endif
   endtask

   task automatic test_random();
      rnd_vld = 1'b1;
      for (int i = 0; i < 40; i++) begin
         pend0.push_back(WIDTH'($urandom));
         pend2.push_back(WIDTH'($urandom));
      end
      run_until_idle("random", 2000);
      rnd_vld = 1'b0;
   endtask

`ifdef SERIALIZER_PARITY_EN
   task automatic test_parity();
      logic [127:0] bits; int nv; logic contig;
      cap0.delete(); cap2.delete();
      pend0.push_back(4'b0111); pend2.push_back(4'b0111);
      run_until_idle("parity", 40);
      valid_bits0(bits, nv, contig);
      checks++;
      if (nv != 5 || !contig || bits[4:0] !== 5'b01111) begin
         errors++;
         $display("FAIL parity_word: got %0d bits %b want 5 bits 01111", nv, bits[4:0]);
      end
   endtask
`endif

   initial begin
      errors = 0; checks = 0; cyc = 0; rnd_vld = 1'b0; max_lvl0 = 0;
      for (int d = 0; d < 2; d++) begin
         m_n[d] = 0; m_free[d] = 0; m_last[d] = 1'b0;
      end
      test_reset();
      test_single();
      test_back_to_back();
      test_gap();
      test_reset_mid();
      test_random();
`ifdef SERIALIZER_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
